ddr2_bank_ctrl: RTL and testbench
=================================

Name: ddr2_bank_ctrl

Overview:
- Per-bank command sequencer for the DDR2 controller.
- Accepts one bank request (row, column, id, length, read/write) on the bank-request handshake.
- Tracks the open-row state of one DRAM bank and enforces tRCD/tRP/tRAS/tRFC/tRTP/tWTP.
- Drives the bank-to-scheduler request/grant lines (ACT/RD/WR/PRE/REF) consumed by the command scheduler; open-page policy.

Parameters:
- ID_W, 4, request id width
- RA_W, 14, row address width
- CA_W, 10, column address width
- TW, 5, width of t_rcd/t_rp/t_ras/t_rtp/t_wtp inputs
- TRFC_W, 8, width of t_rfc input

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  bank request valid
- req_ready  out  1  bank request ready
- req_id  in  ID_W  request id
- req_ra  in  RA_W  row address
- req_ca  in  CA_W  column address
- req_len  in  4  burst length code (carried, not interpreted)
- req_wr  in  1  1=write, 0=read
- t_rcd, t_rp, t_ras, t_rtp, t_wtp  in  TW each  timing values in clk cycles
- t_rfc  in  TRFC_W  refresh cycle time
- ref_pend  in  1  refresh required (level, from refresh timer)
- ref_done  out  1  one-cycle pulse when REF granted
- sch_ra  out  RA_W  row for ACT
- sch_ca  out  CA_W  column for RD/WR
- sch_id  out  ID_W  id of the RD/WR being issued
- act_req, rd_req, wr_req, pre_req, ref_req  out  1 each  command requests
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  in  1 each  scheduler grants

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset outputs: req_ready=0 during reset, 1 the cycle after; all *_req=0; ref_done=0; sch_* = 0.
- Reset internal state: FSM=CLOSED; all timers=0; request buffer empty.
- Reset mid-operation abandons any latched request and any open row with no command issued. The bank is assumed closed.
- Request buffer: one entry. req_ready = buffer empty AND state not REFRESHING AND NOT ref_pend. An accepted request is latched on req_valid&req_ready.
- Request retirement: the entry is freed on the rd_gnt/wr_gnt cycle; req_ready may rise the next cycle. No same-cycle accept on a retire cycle.
- Timers: on a grant, the associated timer loads t_X-1 (0 if t_X=0) and decrements by 1 per cycle, saturating at 0. A command is permitted when its timer is 0, so the earliest next request is grant cycle + max(t_X,1).
  - ACT grant loads rcd and ras.
  - RD grant loads rtp.
  - WR grant loads wtp.
  - PRE grant loads rp.
  - REF grant loads rfc (TRFC_W).
- FSM states and transitions:
  - CLOSED: if ref_pend and rp==0, assert ref_req. Otherwise, if buffer valid and rp==0, assert act_req with sch_ra=buffered ra. act_gnt -> OPEN (open_row := ra). ref_gnt -> REFRESHING.
  - OPEN, buffer valid, ra==open_row (hit): assert rd_req/wr_req per req_wr when rcd==0; sch_ca/sch_id from the buffer. Grant -> stay OPEN.
  - OPEN, (buffer valid and miss) or ref_pend: assert pre_req when ras==0, rtp==0 and wtp==0. pre_gnt -> CLOSED.
  - OPEN, buffer empty and no ref_pend: hold; no request asserted.
  - REFRESHING: no requests. When rfc==0 -> CLOSED. ref_done pulses on the ref_gnt cycle.
- Request rules:
  - At most one *_req asserted per cycle.
  - A request stays asserted, with sch_* stable, until granted.
  - *_req is derived only from registered state and timers (no combinational path from *_gnt to *_req).
  - A grant without a matching request is ignored.
- Priority: ref_pend overrides a pending miss or new ACT, but never aborts a hit RD/WR already requested. After the grant, the bank proceeds to PRE.
- Row width compare is exact over RA_W bits. The timer input value is sampled at grant time.

Test Plan:
- Reset with req_valid=1 -> all *_req=0 during reset; req_ready=1 one cycle after rst deasserts; first act_req follows acceptance.
- Read to closed bank, t_rcd=3, grants given immediately -> act_req at cycle A; rd_req asserts at A+3 with sch_ca=req_ca and sch_id=req_id; req_ready rises at A+4.
- Row hit: second write to open row 0x12 -> wr_req with no ACT/PRE, gated only by rcd.
- Row miss: t_ras=6, t_wtp=4, write then read to a different row -> pre_req no earlier than max(ACT+6, WR+4). Then t_rp=2 -> act_req at PRE+2 with the new row.
- Refresh while OPEN and idle, t_rfc=20 -> pre_req, then ref_req. ref_done pulses on ref_gnt; req_ready stays 0 until 20 cycles after ref_gnt; then CLOSED.
- Delayed grants: hold act_gnt low 5 cycles -> act_req and sch_ra stable throughout; spurious rd_gnt while CLOSED ignored. Zero timings (t_X=0) -> next command one cycle after grant.

Source files
------------

// File: rtl/ddr2_bank_ctrl.sv
// rtl/ddr2_bank_ctrl.sv - DDR2 per-bank command sequencer (open-page, tRCD/tRP/tRAS/tRFC/tRTP/tWTP)
module ddr2_bank_ctrl #(
  parameter int ID_W   = 4,
  parameter int RA_W   = 14,
  parameter int CA_W   = 10,
  parameter int TW     = 5,
  parameter int TRFC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic [RA_W-1:0]   req_ra,
  input  logic [CA_W-1:0]   req_ca,
  input  logic [3:0]        req_len,
  input  logic              req_wr,
  input  logic [TW-1:0]     t_rcd,
  input  logic [TW-1:0]     t_rp,
  input  logic [TW-1:0]     t_ras,
  input  logic [TW-1:0]     t_rtp,
  input  logic [TW-1:0]     t_wtp,
  input  logic [TRFC_W-1:0] t_rfc,
  input  logic              ref_pend,
  output logic              ref_done,
  output logic [RA_W-1:0]   sch_ra,
  output logic [CA_W-1:0]   sch_ca,
  output logic [ID_W-1:0]   sch_id,
  output logic              act_req,
  output logic              rd_req,
  output logic              wr_req,
  output logic              pre_req,
  output logic              ref_req,
  input  logic              act_gnt,
  input  logic              rd_gnt,
  input  logic              wr_gnt,
  input  logic              pre_gnt,
  input  logic              ref_gnt
);

  localparam logic [1:0] ST_CLOSED  = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_REFRESH = 2'd2;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_REF  = 3'd5;

  logic [1:0]        state;
  logic [RA_W-1:0]   open_row;
  logic              buf_valid;
  logic [ID_W-1:0]   buf_id;
  logic [RA_W-1:0]   buf_ra;
  logic [CA_W-1:0]   buf_ca;
  logic              buf_wr;
  logic [TW-1:0]     tm_rcd, tm_ras, tm_rtp, tm_wtp, tm_rp;
  logic [TRFC_W-1:0] tm_rfc;
  logic [2:0]        hold_cmd;
  logic [2:0]        fresh_cmd;
  logic [2:0]        cmd;
  logic              grant;
  logic              accept;

  // Burst length rides along with the request but the bank never looks at it.
  logic unused_len;
  assign unused_len = ^req_len;

  function automatic logic [TW-1:0] t_load(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TW-1:0] t_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic [TRFC_W-1:0] rfc_dec(input logic [TRFC_W-1:0] t);
    return (t == '0) ? '0 : t - TRFC_W'(1);
  endfunction

  always_comb begin
    fresh_cmd = C_NONE;
    case (state)
      ST_CLOSED: begin
        if (tm_rp == '0) begin
          if (ref_pend)       fresh_cmd = C_REF;
          else if (buf_valid) fresh_cmd = C_ACT;
        end
      end
      ST_OPEN: begin
        if (ref_pend || (buf_valid && buf_ra != open_row)) begin
          if (tm_ras == '0 && tm_rtp == '0 && tm_wtp == '0) fresh_cmd = C_PRE;
        end else if (buf_valid && tm_rcd == '0) begin
          fresh_cmd = buf_wr ? C_WR : C_RD;
        end
      end
      default: fresh_cmd = C_NONE;
    endcase
  end

  // An ungranted request is replayed unchanged so ref_pend can never retract it.
  assign cmd = rst ? C_NONE : ((hold_cmd != C_NONE) ? hold_cmd : fresh_cmd);

  assign act_req = (cmd == C_ACT);
  assign rd_req  = (cmd == C_RD);
  assign wr_req  = (cmd == C_WR);
  assign pre_req = (cmd == C_PRE);
  assign ref_req = (cmd == C_REF);

  assign grant = (act_req & act_gnt) | (rd_req & rd_gnt) | (wr_req & wr_gnt) |
                 (pre_req & pre_gnt) | (ref_req & ref_gnt);

  assign ref_done  = ref_req & ref_gnt;
  assign req_ready = !rst && !buf_valid && (state != ST_REFRESH) && !ref_pend;
  assign accept    = req_valid && req_ready;

  assign sch_ra = rst ? '0 : buf_ra;
  assign sch_ca = rst ? '0 : buf_ca;
  assign sch_id = rst ? '0 : buf_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLOSED;
      open_row  <= '0;
      buf_valid <= 1'b0;
      buf_id    <= '0;
      buf_ra    <= '0;
      buf_ca    <= '0;
      buf_wr    <= 1'b0;
      tm_rcd    <= '0;
      tm_ras    <= '0;
      tm_rtp    <= '0;
      tm_wtp    <= '0;
      tm_rp     <= '0;
      tm_rfc    <= '0;
      hold_cmd  <= C_NONE;
    end else begin
      hold_cmd <= grant ? C_NONE : cmd;
      tm_rcd   <= (act_req && act_gnt) ? t_load(t_rcd) : t_dec(tm_rcd);
      tm_ras   <= (act_req && act_gnt) ? t_load(t_ras) : t_dec(tm_ras);
      tm_rtp   <= (rd_req && rd_gnt)   ? t_load(t_rtp) : t_dec(tm_rtp);
      tm_wtp   <= (wr_req && wr_gnt)   ? t_load(t_wtp) : t_dec(tm_wtp);
      tm_rp    <= (pre_req && pre_gnt) ? t_load(t_rp)  : t_dec(tm_rp);
      tm_rfc   <= (ref_req && ref_gnt) ? ((t_rfc == '0) ? '0 : t_rfc - TRFC_W'(1))
                                       : rfc_dec(tm_rfc);

      if (act_req && act_gnt) begin
        state    <= ST_OPEN;
        open_row <= buf_ra;
      end else if (pre_req && pre_gnt) begin
        state <= ST_CLOSED;
      end else if (ref_req && ref_gnt) begin
        state <= ST_REFRESH;
      end else if (state == ST_REFRESH && tm_rfc == '0) begin
        state <= ST_CLOSED;
      end

      if ((rd_req && rd_gnt) || (wr_req && wr_gnt)) begin
        buf_valid <= 1'b0;
      end else if (accept) begin
        buf_valid <= 1'b1;
        buf_id    <= req_id;
        buf_ra    <= req_ra;
        buf_ca    <= req_ca;
        buf_wr    <= req_wr;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_bank_ctrl.sv
// tb/tb_ddr2_bank_ctrl.sv - randomized bench for ddr2_bank_ctrl against a timestamp-based bank model
module tb_ddr2_bank_ctrl;

  localparam int ID_W   = 4;
  localparam int RA_W   = 14;
  localparam int CA_W   = 10;
  localparam int TW     = 5;
  localparam int TRFC_W = 8;

  logic              clk, rst;
  logic              req_valid, req_ready;
  logic [ID_W-1:0]   req_id;
  logic [RA_W-1:0]   req_ra;
  logic [CA_W-1:0]   req_ca;
  logic [3:0]        req_len;
  logic              req_wr;
  logic [TW-1:0]     t_rcd, t_rp, t_ras, t_rtp, t_wtp;
  logic [TRFC_W-1:0] t_rfc;
  logic              ref_pend, ref_done;
  logic [RA_W-1:0]   sch_ra;
  logic [CA_W-1:0]   sch_ca;
  logic [ID_W-1:0]   sch_id;
  logic              act_req, rd_req, wr_req, pre_req, ref_req;
  logic              act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;

  ddr2_bank_ctrl #(.ID_W(ID_W), .RA_W(RA_W), .CA_W(CA_W), .TW(TW), .TRFC_W(TRFC_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_ra(req_ra), .req_ca(req_ca), .req_len(req_len), .req_wr(req_wr),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rtp(t_rtp), .t_wtp(t_wtp), .t_rfc(t_rfc),
    .ref_pend(ref_pend), .ref_done(ref_done),
    .sch_ra(sch_ra), .sch_ca(sch_ca), .sch_id(sch_id),
    .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
    .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: bank phase, one-entry buffer, and the earliest cycle each constraint clears.
  localparam int K_NONE = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_REF = 5;
  localparam int M_CLOSED = 0, M_OPEN = 1, M_REFR = 2;

  int m_st, m_row, m_hold;
  bit m_bv, m_wr;
  int m_id, m_ra, m_ca;
  int ok_rcd, ok_ras, ok_rtp, ok_wtp, ok_rp, ok_rfc;
  bit clr_ref;

  function automatic int ready_at(input int g, input int t);
    return g + ((t == 0) ? 1 : t);
  endfunction

  task automatic model_reset();
    m_st = M_CLOSED; m_row = 0; m_hold = K_NONE; m_bv = 0; m_wr = 0;
    m_id = 0; m_ra = 0; m_ca = 0;
    ok_rcd = 0; ok_ras = 0; ok_rtp = 0; ok_wtp = 0; ok_rp = 0; ok_rfc = 0;
  endtask

  task automatic step_model();
    int  want, cmd;
    bit  exp_ready, granted;
    logic [4:0] vec;
    want = K_NONE;
    if (m_st == M_CLOSED && cyc >= ok_rp) begin
      if (ref_pend) want = K_REF;
      else if (m_bv) want = K_ACT;
    end else if (m_st == M_OPEN) begin
      if (ref_pend || (m_bv && m_ra != m_row)) begin
        if (cyc >= ok_ras && cyc >= ok_rtp && cyc >= ok_wtp) want = K_PRE;
      end else if (m_bv && cyc >= ok_rcd) begin
        want = m_wr ? K_WR : K_RD;
      end
    end
    cmd = (m_hold != K_NONE) ? m_hold : want;
    case (cmd)
      K_ACT:   vec = 5'b10000;
      K_RD:    vec = 5'b01000;
      K_WR:    vec = 5'b00100;
      K_PRE:   vec = 5'b00010;
      K_REF:   vec = 5'b00001;
      default: vec = 5'b00000;
    endcase
    exp_ready = !m_bv && m_st != M_REFR && !ref_pend;
    granted = (cmd == K_ACT && act_gnt) || (cmd == K_RD && rd_gnt) || (cmd == K_WR && wr_gnt) ||
              (cmd == K_PRE && pre_gnt) || (cmd == K_REF && ref_gnt);

    check("req_vec", 32'({act_req, rd_req, wr_req, pre_req, ref_req}), 32'(vec));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("ref_done", 32'(ref_done), 32'(cmd == K_REF && ref_gnt));
    if (cmd == K_ACT) check("sch_ra", 32'(sch_ra), 32'(m_ra));
    if (cmd == K_RD || cmd == K_WR) begin
      check("sch_ca", 32'(sch_ca), 32'(m_ca));
      check("sch_id", 32'(sch_id), 32'(m_id));
    end

    if (granted) begin
      case (cmd)
        K_ACT: begin
          m_st = M_OPEN; m_row = m_ra;
          ok_rcd = ready_at(cyc, int'(t_rcd)); ok_ras = ready_at(cyc, int'(t_ras));
        end
        K_RD:  begin m_bv = 0; ok_rtp = ready_at(cyc, int'(t_rtp)); end
        K_WR:  begin m_bv = 0; ok_wtp = ready_at(cyc, int'(t_wtp)); end
        K_PRE: begin m_st = M_CLOSED; ok_rp = ready_at(cyc, int'(t_rp)); end
        default: begin m_st = M_REFR; ok_rfc = ready_at(cyc, int'(t_rfc)); clr_ref = 1; end
      endcase
    end else if (m_st == M_REFR && cyc >= ok_rfc) begin
      m_st = M_CLOSED;
    end
    m_hold = granted ? K_NONE : cmd;
    if (req_valid && exp_ready) begin
      m_bv = 1; m_id = int'(req_id); m_ra = int'(req_ra); m_ca = int'(req_ca); m_wr = req_wr;
    end
  endtask

  task automatic drive_random();
    int sel;
    req_valid = ($urandom % 3) == 0;
    sel = int'($urandom % 4);
    req_ra  = (sel == 0 || sel == 2) ? 14'h12 : (sel == 1) ? 14'h34 : RA_W'($urandom);
    req_ca  = CA_W'($urandom);
    req_id  = ID_W'($urandom);
    req_len = 4'($urandom);
    req_wr  = 1'($urandom);
    if (clr_ref) begin
      ref_pend = 1'b0; clr_ref = 0;
    end else if (!ref_pend && ($urandom % 80) == 0) begin
      ref_pend = 1'b1;
    end
    act_gnt = ($urandom % 3) == 0;
    rd_gnt  = ($urandom % 3) == 0;
    wr_gnt  = ($urandom % 3) == 0;
    pre_gnt = ($urandom % 3) == 0;
    ref_gnt = ($urandom % 3) == 0;
  endtask

  task automatic set_timings(input int phase);
    if (phase == 0) begin
      t_rcd = 5'd3; t_ras = 5'd6; t_wtp = 5'd4; t_rp = 5'd2; t_rtp = 5'd1; t_rfc = 8'd20;
    end else if (phase == 1) begin
      t_rcd = '0; t_ras = '0; t_wtp = '0; t_rp = '0; t_rtp = '0; t_rfc = '0;
    end else begin
      t_rcd = TW'($urandom_range(0, 8)); t_ras = TW'($urandom_range(0, 12));
      t_wtp = TW'($urandom_range(0, 8)); t_rp  = TW'($urandom_range(0, 8));
      t_rtp = TW'($urandom_range(0, 8)); t_rfc = TRFC_W'($urandom_range(0, 25));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_id = '0; req_ra = 14'h12; req_ca = '0; req_len = '0;
    req_wr = 1'b0; ref_pend = 1'b0; clr_ref = 0;
    act_gnt = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0; pre_gnt = 1'b0; ref_gnt = 1'b0;
    set_timings(0);
    model_reset();

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      cyc++;
      if (c % 400 == 0) set_timings(c / 400);
      if (c < 3 || (c >= 3000 && c < 3003)) begin
        rst = 1'b1;
        drive_random();
        #1;
        check("rst_reqs", 32'({act_req, rd_req, wr_req, pre_req, ref_req}), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_done", 32'(ref_done), 32'(0));
        check("rst_sch", 32'({sch_ra, sch_ca, sch_id}), 32'(0));
        model_reset();
        clr_ref = 0;
      end else begin
        rst = 1'b0;
        drive_random();
        #1;
        step_model();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
